mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/muldiv_pkg.sv | 34 +++
 rtl/mul_div_unit_hilo_regs.sv | 46 ++++
 rtl/mul_div_unit.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_mul_div_unit.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for mul_div_unit.
// The DIV state exists only when MUL_DIV_UNIT_DIV_EN is defined.
package muldiv_pkg;

    // Operation select encodings; 3'd7 is reserved and behaves like OP_NONE
    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULTU = 3'd1,
        OP_MULT  = 3'd2,
        OP_DIVU  = 3'd3,
        OP_DIV   = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } op_e;

    // Sequencer states; busy is high in every state except ST_IDLE
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MUL   = 2'd1,
`ifdef MUL_DIV_UNIT_DIV_EN
        ST_DIV   = 2'd2,
`endif
        ST_FIXUP = 2'd3
    } state_e;

    // Cycles from the accepting edge to the completion edge: WIDTH steps plus FIXUP
    localparam int unsigned LAT_EXTRA = 32'd1;

    function automatic int unsigned completion_latency(input int unsigned width);
        return width + LAT_EXTRA;
    endfunction

endpackage

// File: rtl/mul_div_unit_hilo_regs.sv
// hilo_regs: architectural HI/LO registers.
// A completed result writes both halves; MTHI/MTLO each write one half from a.
module hilo_regs #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             res_we,
    input  logic [WIDTH-1:0] res_hi,
    input  logic [WIDTH-1:0] res_lo,
    input  logic             mthi_we,
    input  logic             mtlo_we,
    input  logic [WIDTH-1:0] mt_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;

    // HI/LO storage: result write has precedence; otherwise hold or take MTHI/MTLO data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_r <= {WIDTH{1'b0}};
            lo_r <= {WIDTH{1'b0}};
        end else if (res_we) begin
            hi_r <= res_hi;
            lo_r <= res_lo;
        end else begin
            if (mthi_we) begin
                hi_r <= mt_data;
            end else begin
                hi_r <= hi_r;
            end
            if (mtlo_we) begin
                lo_r <= mt_data;
            end else begin
                lo_r <= lo_r;
            end
        end
    end

    assign hi = hi_r;
    assign lo = lo_r;

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide unit with HI/LO result registers.
// Multiplies by shift-add and divides by restoring shift-subtract, one bit per
// cycle on operand magnitudes, then applies signs in a final FIXUP cycle.
// Define MUL_DIV_UNIT_DIV_EN to build in the divider; without it DIV/DIVU are
// treated as OP_NONE.
module mul_div_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int AW = 2 * WIDTH;

    state_e           state_r;
    logic [CW-1:0]    cnt_r;
    logic [AW-1:0]    acc_r;      // MUL: {partial product, multiplier}; DIV: {remainder, quotient}
    logic [WIDTH-1:0] opnd_r;     // MUL: |multiplicand|; DIV: |divisor|
    logic             neg_res_r;  // product / quotient must be negated
    logic             busy_r;
    logic             done_r;

    logic             accept_mul_s;
    logic             signed_op_s;
    logic             mthi_we_s;
    logic             mtlo_we_s;
    logic             sign_a_s;
    logic             sign_b_s;
    logic [WIDTH-1:0] abs_a_s;
    logic [WIDTH-1:0] abs_b_s;
    logic [WIDTH:0]   mul_sum_s;
    logic [AW-1:0]    mul_next_s;
    logic [AW-1:0]    prod_s;
    logic             res_we_s;
    logic [WIDTH-1:0] res_hi_s;
    logic [WIDTH-1:0] res_lo_s;

`ifdef MUL_DIV_UNIT_DIV_EN
    logic             is_div_r;
    logic             neg_rem_r;  // remainder takes the dividend's sign
    logic             accept_div_s;
    logic [WIDTH:0]   div_shift_s;
    logic [WIDTH:0]   div_diff_s;
    logic [AW-1:0]    div_next_s;
    logic [WIDTH-1:0] quo_s;
    logic [WIDTH-1:0] rem_s;
`endif

    // Request decode: only sampled while idle, so a start during an operation is dropped
    always_comb begin
        accept_mul_s = 1'b0;
        signed_op_s  = 1'b0;
        mthi_we_s    = 1'b0;
        mtlo_we_s    = 1'b0;
`ifdef MUL_DIV_UNIT_DIV_EN
        accept_div_s = 1'b0;
`endif
        if ((state_r == ST_IDLE) && start) begin
            case (op)
                OP_MULTU: accept_mul_s = 1'b1;
                OP_MULT: begin
                    accept_mul_s = 1'b1;
                    signed_op_s  = 1'b1;
                end
`ifdef MUL_DIV_UNIT_DIV_EN
                OP_DIVU: accept_div_s = 1'b1;
                OP_DIV: begin
                    accept_div_s = 1'b1;
                    signed_op_s  = 1'b1;
                end
`endif
                OP_MTHI: mthi_we_s = 1'b1;
                OP_MTLO: mtlo_we_s = 1'b1;
                default: accept_mul_s = 1'b0;
            endcase
        end else begin
            accept_mul_s = 1'b0;
        end
    end

    // Operand magnitudes; MIN maps onto its own bit pattern, read as unsigned 2^(WIDTH-1)
    always_comb begin
        sign_a_s = signed_op_s & a[WIDTH-1];
        sign_b_s = signed_op_s & b[WIDTH-1];
        if (sign_a_s) begin
            abs_a_s = {WIDTH{1'b0}} - a;
        end else begin
            abs_a_s = a;
        end
        if (sign_b_s) begin
            abs_b_s = {WIDTH{1'b0}} - b;
        end else begin
            abs_b_s = b;
        end
    end

    // One shift-add multiply step: add multiplicand into the top half when the LSB is set, shift right
    always_comb begin
        if (acc_r[0]) begin
            mul_sum_s = {1'b0, acc_r[AW-1:WIDTH]} + {1'b0, opnd_r};
        end else begin
            mul_sum_s = {1'b0, acc_r[AW-1:WIDTH]};
        end
        mul_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
    end

`ifdef MUL_DIV_UNIT_DIV_EN
    // One restoring divide step; a zero divisor yields all-ones quotient and remainder = |a|
    always_comb begin
        div_shift_s = {acc_r[AW-1:WIDTH], acc_r[WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, opnd_r};
        if (div_shift_s >= {1'b0, opnd_r}) begin
            div_next_s = {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
        end else begin
            div_next_s = {div_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
        end
    end
`endif

    // Sign fixup of the raw magnitude result into HI/LO form
    always_comb begin
        if (neg_res_r) begin
            prod_s = {AW{1'b0}} - acc_r;
        end else begin
            prod_s = acc_r;
        end
        res_hi_s = prod_s[AW-1:WIDTH];
        res_lo_s = prod_s[WIDTH-1:0];
`ifdef MUL_DIV_UNIT_DIV_EN
        quo_s = acc_r[WIDTH-1:0];
        rem_s = acc_r[AW-1:WIDTH];
        if (is_div_r) begin
            // hi = a on divide by zero falls out of rem = |a| with the dividend's sign
            if (neg_rem_r) begin
                res_hi_s = {WIDTH{1'b0}} - rem_s;
            end else begin
                res_hi_s = rem_s;
            end
            if (opnd_r == {WIDTH{1'b0}}) begin
                res_lo_s = {WIDTH{1'b1}};
            end else if (neg_res_r) begin
                res_lo_s = {WIDTH{1'b0}} - quo_s;
            end else begin
                res_lo_s = quo_s;
            end
        end else begin
            res_hi_s = prod_s[AW-1:WIDTH];
        end
`endif
    end

    // Completion writes HI/LO unless a flush arrives in the same cycle
    assign res_we_s = (state_r == ST_FIXUP) && !flush;

    // Sequencer: accept, iterate WIDTH steps, fix up, with flush abandoning any busy state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CW{1'b0}};
            acc_r     <= {AW{1'b0}};
            opnd_r    <= {WIDTH{1'b0}};
            neg_res_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
`ifdef MUL_DIV_UNIT_DIV_EN
            is_div_r  <= 1'b0;
            neg_rem_r <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_mul_s) begin
                        state_r   <= ST_MUL;
                        busy_r    <= 1'b1;
                        cnt_r     <= CW'(WIDTH);
                        acc_r     <= {{WIDTH{1'b0}}, abs_b_s};
                        opnd_r    <= abs_a_s;
                        neg_res_r <= sign_a_s ^ sign_b_s;
`ifdef MUL_DIV_UNIT_DIV_EN
                        is_div_r  <= 1'b0;
                        neg_rem_r <= 1'b0;
`endif
                    end
`ifdef MUL_DIV_UNIT_DIV_EN
                    else if (accept_div_s) begin
                        state_r   <= ST_DIV;
                        busy_r    <= 1'b1;
                        cnt_r     <= CW'(WIDTH);
                        acc_r     <= {{WIDTH{1'b0}}, abs_a_s};
                        opnd_r    <= abs_b_s;
                        neg_res_r <= sign_a_s ^ sign_b_s;
                        is_div_r  <= 1'b1;
                        neg_rem_r <= sign_a_s;
                    end
`endif
                    else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_MUL: begin
                    if (flush) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        cnt_r   <= {CW{1'b0}};
                    end else begin
                        acc_r <= mul_next_s;
                        cnt_r <= cnt_r - CW'(1);
                        if (cnt_r == CW'(1)) begin
                            state_r <= ST_FIXUP;
                        end else begin
                            state_r <= ST_MUL;
                        end
                    end
                end
`ifdef MUL_DIV_UNIT_DIV_EN
                ST_DIV: begin
                    if (flush) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        cnt_r   <= {CW{1'b0}};
                    end else begin
                        acc_r <= div_next_s;
                        cnt_r <= cnt_r - CW'(1);
                        if (cnt_r == CW'(1)) begin
                            state_r <= ST_FIXUP;
                        end else begin
                            state_r <= ST_DIV;
                        end
                    end
                end
`endif
                ST_FIXUP: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    cnt_r   <= {CW{1'b0}};
                    if (!flush) begin
                        done_r <= 1'b1;
                    end else begin
                        done_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    cnt_r   <= {CW{1'b0}};
                end
            endcase
        end
    end

    hilo_regs #(
        .WIDTH(WIDTH)
    ) u_hilo_regs (
        .clk     (clk),
        .rst     (rst),
        .res_we  (res_we_s),
        .res_hi  (res_hi_s),
        .res_lo  (res_lo_s),
        .mthi_we (mthi_we_s),
        .mtlo_we (mtlo_we_s),
        .mt_data (a),
        .hi      (hi),
        .lo      (lo)
    );

    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: scoreboard bench for mul_div_unit (WIDTH=32).
// Expected HI/LO come from a plain-arithmetic reference; a monitor checks
// every done pulse against the queue, including its arrival cycle.
module tb_mul_div_unit;
    import muldiv_pkg::*;

    localparam int W   = 32;
    localparam int LAT = W + 1;
    localparam logic [W-1:0] MIN_V  = 32'h8000_0000;
    localparam logic [W-1:0] ONES_V = 32'hFFFF_FFFF;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] a = 32'd0;
    logic [W-1:0] b = 32'd0;
    logic         flush = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           due;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         mon_e;
    int           cyc = 0;
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] model_hi = 32'd0;
    logic [W-1:0] model_lo = 32'd0;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference results as {hi, lo}, straight from the arithmetic definitions
    function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
        longint       sx;
        longint       sy;
        longint       q;
        longint       r;
        logic [63:0]  p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        p  = 64'd0;
        case (o)
            3'd1: p = {32'd0, x} * {32'd0, y};
            3'd2: p = 64'(sx * sy);
            3'd3: begin
                if (y == 32'd0) p = {x, ONES_V};
                else            p = {x % y, x / y};
            end
            3'd4: begin
                if (y == 32'd0)                       p = {x, ONES_V};
                else if (x == MIN_V && y == ONES_V)   p = {32'd0, MIN_V};
                else begin
                    q = sx / sy;
                    r = sx % sy;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: p = 64'd0;
        endcase
        return p;
    endfunction

    function automatic bit is_result_op(input logic [2:0] o);
`ifdef MUL_DIV_UNIT_DIV_EN
        return (o == 3'd1) || (o == 3'd2) || (o == 3'd3) || (o == 3'd4);
`else
        return (o == 3'd1) || (o == 3'd2);
`endif
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return MIN_V;
            2:       return ONES_V;
            3:       return 32'd1;
            default: return W'($urandom);
        endcase
    endfunction

    // Called at posedge+1; returns once busy is low, bounded
    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy !== 1'b0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
        end
    endtask

    // Issue one request at the next edge and check its immediate effect
    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input bit expect_done, input bit with_flush);
        logic [63:0] r;
        exp_t        e;
        wait_idle();
        start = 1'b1; op = o; a = x; b = y; flush = with_flush;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        op = 3'($urandom); a = W'($urandom); b = W'($urandom);
        if (is_result_op(o)) begin
            check("busy_after_accept", 64'(busy), 64'd1);
            if (expect_done) begin
                r     = ref_op(o, x, y);
                e.hi  = r[63:32];
                e.lo  = r[31:0];
                e.due = cyc + LAT;
                exp_q.push_back(e);
                model_hi = r[63:32];
                model_lo = r[31:0];
            end
        end else if (o == 3'd5) begin
            check("mthi_busy", 64'(busy), 64'd0);
            check("mthi_hi", 64'(hi), 64'(x));
            check("mthi_lo", 64'(lo), 64'(model_lo));
            model_hi = x;
        end else if (o == 3'd6) begin
            check("mtlo_busy", 64'(busy), 64'd0);
            check("mtlo_lo", 64'(lo), 64'(x));
            check("mtlo_hi", 64'(hi), 64'(model_hi));
            model_lo = x;
        end else begin
            check("none_busy", 64'(busy), 64'd0);
            check("none_hilo", {hi, lo}, {model_hi, model_lo});
        end
    endtask

    // Monitor: every done pulse must match the oldest expectation, on its due cycle
    always @(negedge clk) begin
        if (rst === 1'b1 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL done_unexpected: done=1 at cycle %0d, required no pulse", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("result_hi", 64'(hi), 64'(mon_e.hi));
                check("result_lo", 64'(lo), 64'(mon_e.lo));
                check("done_cycle", 64'(cyc), 64'(mon_e.due));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int           nb;
        logic [W-1:0] old_hi;
        logic [W-1:0] old_lo;
        logic [2:0]   ro;

        // Reset state
        #13;
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        #4 rst = 1'b1;
        @(posedge clk); #1;

        // MULTU 7*6: busy for LAT cycles
        issue(3'd1, 32'd7, 32'd6, 1'b1, 1'b0);
        nb = 0;
        while (busy === 1'b1 && nb < 100) begin
            nb++;
            @(posedge clk); #1;
        end
        check("multu_busy_cycles", 64'(nb), 64'(LAT));
        check("multu_hilo_const", {hi, lo}, 64'h0000_0000_0000_002A);

        // MULT -3*5 with an ignored MTLO at cycle 5; HI/LO show old values while busy
        old_hi = model_hi;
        old_lo = model_lo;
        issue(3'd2, 32'hFFFF_FFFD, 32'd5, 1'b1, 1'b0);
        repeat (4) begin @(posedge clk); #1; end
        check("busy_old_hi", 64'(hi), 64'(old_hi));
        check("busy_old_lo", 64'(lo), 64'(old_lo));
        start = 1'b1; op = 3'd6; a = 32'h1234_5678;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle();
        check("mult_hilo_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);

        // Signed divide and divide by zero (plain NONE when the divider is absent)
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
        issue(3'd3, 32'd10, 32'd0, 1'b1, 1'b0);
        issue(3'd4, MIN_V, ONES_V, 1'b1, 1'b0);

        // MTHI 5, then MULTU flushed at cycle 10
        issue(3'd5, 32'd5, 32'd0, 1'b0, 1'b0);
        issue(3'd1, 32'd9, 32'd9, 1'b0, 1'b0);
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_hi", 64'(hi), 64'd5);
        check("flush_lo", 64'(lo), 64'(model_lo));

        // Flush coinciding with the FIXUP edge wins over completion
        issue(3'd2, 32'd123, 32'hFFFF_FF00, 1'b0, 1'b0);
        repeat (LAT - 1) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("fixup_flush_busy", 64'(busy), 64'd0);
        check("fixup_flush_hilo", {hi, lo}, {model_hi, model_lo});

        // Flush while idle does not block a start
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);

        // Asynchronous reset in the middle of an operation
        issue(3'd4, 32'd1000, 32'd7, 1'b0, 1'b0);
        issue(3'd1, 32'd3, 32'd3, 1'b0, 1'b0);
        repeat (5) begin @(posedge clk); #1; end
        #2 rst = 1'b0;
        #1;
        check("arst_hi", 64'(hi), 64'd0);
        check("arst_lo", 64'(lo), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        model_hi = 32'd0;
        model_lo = 32'd0;
        #3 rst = 1'b1;
        @(posedge clk); #1;
        issue(3'd1, 32'hDEAD_BEEF, 32'h0000_1001, 1'b1, 1'b0);

        // Randomized operations with occasional starts poked while busy
        for (int i = 0; i < 60; i++) begin
            ro = 3'($urandom_range(0, 7));
            issue(ro, pick(), pick(), 1'b1, 1'b0);
            if (busy === 1'b1 && $urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 20)) begin @(posedge clk); #1; end
                if (busy === 1'b1) begin
                    start = 1'b1; op = 3'($urandom); a = W'($urandom); b = W'($urandom);
                    @(posedge clk); #1;
                    start = 1'b0;
                end
            end
        end

        wait_idle();
        repeat (3) begin @(posedge clk); #1; end
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("final_hilo", {hi, lo}, {model_hi, model_lo});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
